if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the five-stage MIPS pipeline. It sits directly upstream of the ID-stage decoder and control unit.
- Owns the PC and addresses instruction memory.
- Owns the IF/ID pipeline register that feeds decode.
- Applies branch/jump redirects, hazard stalls and flushes.
- Freezes fetch when the halt word is fetched.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
IMEM_AW, 10, instruction-memory word-address width
HALT_WORD, 32'hFFFF_FFFF, encoding that terminates fetch

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
imem_addr  out  IMEM_AW  word address, equal to pc[IMEM_AW+1:2]
imem_rdata  in  32  instruction at imem_addr, combinational, same cycle
stall  in  1  hazard unit: hold PC and IF/ID (load-use)
branch_taken  in  1  EX stage: taken beq/bne this cycle
branch_target  in  32  EX stage: branch destination byte address
jump  in  1  ID stage: j/jal decoded this cycle
jump_target  in  32  ID stage: jump destination byte address
pc  out  32  current fetch PC
if_id_instruction  out  32  instruction presented to decode
if_id_pc_plus4  out  32  PC+4 of that instruction
if_id_valid  out  1  1 = real instruction, 0 = bubble
halted  out  1  fetch frozen on HALT_WORD
fetch_count  out  32  count of valid instructions written to IF/ID

Behaviour:
- Reset (sync, active-high, all state, regardless of other inputs):
  - pc=RESET_PC, if_id_instruction=0, if_id_pc_plus4=0, if_id_valid=0, halted=0, fetch_count=0, state=RUN.
- Bubble: instruction 32'h0 (sll $0,$0,0), valid=0. Decode treats it as a harmless write to $0.
- Redirect targets always have bits [1:0] forced to 0. PC arithmetic is modulo 2^32; PC+4 wraps 0xFFFF_FFFC -> 0.
- Per-cycle priority, highest first:
  1. branch_taken: pc<=branch_target; IF/ID<=bubble; state<=RUN. Overrides stall (the branch is older than the stalled instruction) and overrides jump (the younger jump is squashed).
  2. stall: pc, IF/ID, state and fetch_count all hold. Any jump asserted this cycle is ignored; the stalled ID instruction re-asserts it later.
  3. jump: pc<=jump_target; IF/ID<=bubble (squashes the sequential fetch).
  4. Normal operation, by state:
     - RUN with imem_rdata!=HALT_WORD: IF/ID<={imem_rdata, pc+4, valid=1}; pc<=pc+4.
     - RUN with imem_rdata==HALT_WORD: IF/ID<={HALT_WORD, pc+4, valid=1}; pc holds; state<=HALTED.
     - HALTED: pc holds; IF/ID<=bubble (the halt word drains downstream).
- State machine: RUN -> HALTED on halt capture (rule 4). HALTED -> RUN only on branch_taken (the halt was speculative) or reset. Jump is not possible in HALTED: an older jump would already have redirected before the halt was captured.
- halted = (state==HALTED), registered.
- fetch_count increments by 1 (wrap at 2^32) on every edge where a valid=1 entry is written into IF/ID. This includes the halt word. Bubbles, stalls and held cycles do not count.
- imem_addr is combinational from pc; no other output is combinational from inputs.

Test Plan:
- Reset then 4 free cycles, imem returning 0x20080001 (addi) at every address:
  - pc sequence 0,4,8,12,16.
  - if_id_pc_plus4 = 4,8,12,16.
  - fetch_count=4, if_id_valid=1.
- Stall held 2 cycles at pc=8: pc stays 8, IF/ID unchanged, fetch_count unchanged. On release, resumes with pc=12 next cycle.
- branch_taken=1, branch_target=0x41 with stall=1 and jump=1 in the same cycle: next pc=0x40, IF/ID bubble (valid=0, instr=0), fetch_count unchanged.
- jump=1, jump_target=0x100 at pc=0x10: next pc=0x100, IF/ID bubble. Following cycle: IF/ID holds the instruction at 0x100 with pc_plus4=0x104.
- HALT_WORD at pc=0x20:
  - IF/ID={0xFFFFFFFF, 0x24, valid=1}, halted=1, pc frozen at 0x20.
  - Next cycle IF/ID=bubble.
  - fetch_count includes the halt word.
- In HALTED, branch_taken=1, target=0x80: halted=0, pc=0x80, fetch resumes. Separately, reset asserted mid-HALTED: all outputs return to reset values in one cycle.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register. It applies branch and
// jump redirects, hazard stalls, and the halt-word freeze.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 10,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump,
  input  logic [31:0]        jump_target,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_instruction,
  output logic [31:0]        if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] instr_r;
  logic [31:0] instr_s;
  logic [31:0] pc4_r;
  logic [31:0] pc4_s;
  logic        valid_r;
  logic        valid_s;
  logic        halted_r;
  logic [31:0] count_r;
  logic [31:0] count_s;
  logic [31:0] pc_plus4_s;

  assign pc_plus4_s = pc_r + 32'd4;

  // Next-state selection: branch beats stall beats jump beats sequential fetch.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    pc4_s   = pc4_r;
    valid_s = valid_r;
    count_s = count_r;
    if (branch_taken) begin
      pc_s    = {branch_target[31:2], 2'b00};
      instr_s = BUBBLE_INSTR;
      pc4_s   = 32'h0000_0000;
      valid_s = 1'b0;
      state_s = ST_RUN;
    end else if (stall) begin
      state_s = state_r;
    end else if (jump) begin
      pc_s    = {jump_target[31:2], 2'b00};
      instr_s = BUBBLE_INSTR;
      pc4_s   = 32'h0000_0000;
      valid_s = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          instr_s = imem_rdata;
          pc4_s   = pc_plus4_s;
          valid_s = 1'b1;
          count_s = count_r + 32'd1;
          if (imem_rdata == HALT_WORD) begin
            // PC stays on the halt word so a later branch can restart cleanly.
            pc_s    = pc_r;
            state_s = ST_HALTED;
          end else begin
            pc_s    = pc_plus4_s;
            state_s = ST_RUN;
          end
        end
        ST_HALTED: begin
          instr_s = BUBBLE_INSTR;
          pc4_s   = 32'h0000_0000;
          valid_s = 1'b0;
        end
        default: begin
          instr_s = BUBBLE_INSTR;
          pc4_s   = 32'h0000_0000;
          valid_s = 1'b0;
          state_s = ST_RUN;
        end
      endcase
    end
  end

  // State, PC, IF/ID and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_RUN;
      pc_r     <= RESET_PC;
      instr_r  <= BUBBLE_INSTR;
      pc4_r    <= 32'h0000_0000;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
      count_r  <= 32'h0000_0000;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      instr_r  <= instr_s;
      pc4_r    <= pc4_s;
      valid_r  <= valid_s;
      halted_r <= (state_s == ST_HALTED);
      count_r  <= count_s;
    end
  end

  assign imem_addr         = pc_r[IMEM_AW+1:2];
  assign pc                = pc_r;
  assign if_id_instruction = instr_r;
  assign if_id_pc_plus4    = pc4_r;
  assign if_id_valid       = valid_r;
  assign halted            = halted_r;
  assign fetch_count       = count_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; the imem model returns addi everywhere
// except at halt_pc, where it returns the halt word.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] halt_pc;

  int total;
  int bad;

  localparam logic [31:0] ADDI = 32'h2008_0001;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  if_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .pc(pc),
    .if_id_instruction(if_id_instruction), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  assign imem_rdata = (imem_addr == halt_pc[11:2]) ? HALT : ADDI;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_valid, input logic e_halt,
                           input logic [31:0] e_cnt);
    check_eq({tag, ".pc"}, pc, e_pc);
    check_eq({tag, ".instr"}, if_id_instruction, e_instr);
    if (e_valid) check_eq({tag, ".pc4"}, if_id_pc_plus4, e_pc4);
    check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    check_eq({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halt});
    check_eq({tag, ".count"}, fetch_count, e_cnt);
  endtask

  initial begin
    total = 0;
    bad = 0;
    halt_pc = 32'h0000_0020;
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    jump = 1'b0;
    jump_target = 32'h0;
    @(negedge clk);
    cyc();
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    check_eq("reset.pc4", if_id_pc_plus4, 32'h0);
    reset = 1'b0;

    for (int i = 1; i <= 2; i++) begin
      cyc();
      check_all("run", 32'(4 * i), ADDI, 32'(4 * i), 1'b1, 1'b0, 32'(i));
    end

    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_all("stall", 32'h8, ADDI, 32'h8, 1'b1, 1'b0, 32'd2);
    end
    stall = 1'b0;
    cyc();
    check_all("release", 32'hC, ADDI, 32'hC, 1'b1, 1'b0, 32'd3);
    cyc();
    check_all("run4", 32'h10, ADDI, 32'h10, 1'b1, 1'b0, 32'd4);
    check_eq("imem_addr", {22'd0, imem_addr}, 32'h4);

    // Jump at 0x10, stall-free.
    jump = 1'b1;
    jump_target = 32'h0000_0100;
    cyc();
    check_all("jump", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 32'd4);
    jump = 1'b0;
    cyc();
    check_all("after_jump", 32'h104, ADDI, 32'h104, 1'b1, 1'b0, 32'd5);

    // Branch beats simultaneous stall and jump; low target bits are dropped.
    branch_taken = 1'b1;
    branch_target = 32'h0000_0041;
    stall = 1'b1;
    jump = 1'b1;
    jump_target = 32'h0000_0200;
    cyc();
    check_all("br_prio", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5);
    stall = 1'b0;
    jump = 1'b0;
    branch_target = 32'h0000_0018;
    cyc();
    check_all("br18", 32'h18, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5);
    branch_taken = 1'b0;
    cyc();
    check_all("run1c", 32'h1C, ADDI, 32'h1C, 1'b1, 1'b0, 32'd6);
    cyc();
    check_all("run20", 32'h20, ADDI, 32'h20, 1'b1, 1'b0, 32'd7);

    // Halt word fetched at 0x20.
    cyc();
    check_all("halt_cap", 32'h20, HALT, 32'h24, 1'b1, 1'b1, 32'd8);
    cyc();
    check_all("halt_drain", 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 32'd8);
    cyc();
    check_all("halt_hold", 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 32'd8);

    branch_taken = 1'b1;
    branch_target = 32'h0000_0080;
    cyc();
    check_all("halt_br", 32'h80, 32'h0, 32'h0, 1'b0, 1'b0, 32'd8);
    branch_taken = 1'b0;
    cyc();
    check_all("resume", 32'h84, ADDI, 32'h84, 1'b1, 1'b0, 32'd9);

    // Halt again, then reset while halted (with a branch also asserted).
    branch_taken = 1'b1;
    branch_target = 32'h0000_0020;
    cyc();
    branch_taken = 1'b0;
    cyc();
    check_all("halt2", 32'h20, HALT, 32'h24, 1'b1, 1'b1, 32'd10);
    reset = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0300;
    cyc();
    check_all("reset_halt", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    check_eq("reset_halt.pc4", if_id_pc_plus4, 32'h0);
    reset = 1'b0;

    // PC+4 wraps from the top of the address space.
    branch_target = 32'hFFFF_FFFE;
    cyc();
    check_all("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    check_eq("imem_addr_top", {22'd0, imem_addr}, 32'h3FF);
    branch_taken = 1'b0;
    cyc();
    check_all("wrap", 32'h0, ADDI, 32'h0, 1'b1, 1'b0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
